// File: rtl/fft8_pkg.sv
// fft8_pkg: shared types, sizes and butterfly address helper
// for the 8-point radix-2 DIT FFT sequencer.
package fft8_pkg;

  localparam int ADDR_W       = 3;
  localparam int TW_W         = 2;
  localparam int NUM_STAGES   = 3;
  localparam int BF_PER_STAGE = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [TW_W-1:0]   tw;
  } bf_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
  } wb_t;

  // span = 1<<s, group = k>>s, pos = k & (span-1)
  function automatic bf_t bf_calc(
    input logic [1:0] s,
    input logic [1:0] k
  );
    logic [2:0] span;
    logic [2:0] grp;
    logic [2:0] pos;
    bf_t        r;
    span     = 3'd1 << s;
    grp      = {1'b0, k} >> s;
    pos      = {1'b0, k} & (span - 3'd1);
    r.addr_a = (grp << (s + 2'd1)) + pos;
    r.addr_b = r.addr_a + span;
    r.tw     = pos[1:0] << (2'd2 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft8_ctrl_if.sv
// fft8_ctrl_if: start/done handshake and butterfly issue bus.
// FFT8_CTRL_INVERSE_EN adds i_inverse / o_tw_conj.
interface fft8_ctrl_if;
  import fft8_pkg::*;

  logic              i_start;
  logic              i_abort;
  logic              o_busy;
  logic              o_load;
  logic              o_bf_valid;
  logic [ADDR_W-1:0] o_addr_a;
  logic [ADDR_W-1:0] o_addr_b;
  logic [TW_W-1:0]   o_tw_idx;
  logic [1:0]        o_stage;
  logic              o_wb_valid;
  logic [ADDR_W-1:0] o_wb_addr_a;
  logic [ADDR_W-1:0] o_wb_addr_b;
  logic              o_done;
`ifdef FFT8_CTRL_INVERSE_EN
  logic              i_inverse;
  logic              o_tw_conj;
`endif

  modport master (
`ifdef FFT8_CTRL_INVERSE_EN
    output i_inverse,
    input  o_tw_conj,
`endif
    output i_start, i_abort,
    input  o_busy, o_load, o_bf_valid,
    input  o_addr_a, o_addr_b, o_tw_idx, o_stage,
    input  o_wb_valid, o_wb_addr_a, o_wb_addr_b,
    input  o_done
  );

  modport slave (
`ifdef FFT8_CTRL_INVERSE_EN
    input  i_inverse,
    output o_tw_conj,
`endif
    input  i_start, i_abort,
    output o_busy, o_load, o_bf_valid,
    output o_addr_a, o_addr_b, o_tw_idx, o_stage,
    output o_wb_valid, o_wb_addr_a, o_wb_addr_b,
    output o_done
  );

endinterface

// File: rtl/fft8_wb_delay.sv
// fft8_wb_delay: latency-matched write-back tracker,
// a LATENCY-deep shift of {valid, addr_a, addr_b} with flush.
module fft8_wb_delay
  import fft8_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o
);

  wb_t sr_q [LATENCY];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= '{valid: valid_i,
                   addr_a: addr_a_i,
                   addr_b: addr_b_i};
      for (int i = 1; i < LATENCY; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign valid_o  = sr_q[LATENCY-1].valid;
  assign addr_a_o = sr_q[LATENCY-1].addr_a;
  assign addr_b_o = sr_q[LATENCY-1].addr_b;

endmodule

// File: rtl/fft8_ctrl.sv
// fft8_ctrl: 8-point DIT FFT sequencer (load, 3x4 butterflies, drains).
// FFT8_CTRL_INVERSE_EN enables the twiddle-conjugate (IFFT) option.
module fft8_ctrl
  import fft8_pkg::*;
#(
  parameter int NUM_POINTS = 8,
  parameter int BF_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  fft8_ctrl_if.slave  bus
);

  localparam logic [1:0] LAST_K   = 2'(NUM_POINTS / 2 - 1);
  localparam logic [1:0] LAST_S   = 2'(NUM_STAGES - 1);
  localparam logic [2:0] LAST_CNT = 3'(BF_LATENCY - 1);

  state_e     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [1:0] k_q, k_d;
  logic [2:0] cnt_q, cnt_d;
  bf_t        bf_d;
  logic       abort_hit;

  logic              busy_q, load_q, bfv_q, done_q;
  logic [ADDR_W-1:0] a_q, b_q;
  logic [TW_W-1:0]   tw_q;
  logic [1:0]        st_q;

  assign abort_hit = bus.i_abort && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start && !bus.i_abort) state_d = LOAD;
      end
      LOAD: begin
        state_d = ISSUE;
        stage_d = 2'd0;
        k_d     = 2'd0;
      end
      ISSUE: begin
        if (k_q == LAST_K) begin
          state_d = DRAIN;
          cnt_d   = 3'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      DRAIN: begin
        if (cnt_q != LAST_CNT) begin
          cnt_d = cnt_q + 3'd1;
        end else if (stage_q < LAST_S) begin
          state_d = ISSUE;
          stage_d = stage_q + 2'd1;
          k_d     = 2'd0;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
    bf_d = bf_calc(stage_d, k_d);
  end

  // outputs are registered from the next state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      bfv_q   <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      busy_q  <= state_d != IDLE;
      load_q  <= state_d == LOAD;
      bfv_q   <= state_d == ISSUE;
      done_q  <= state_d == DONE;
      a_q     <= (state_d == ISSUE) ? bf_d.addr_a : '0;
      b_q     <= (state_d == ISSUE) ? bf_d.addr_b : '0;
      tw_q    <= (state_d == ISSUE) ? bf_d.tw : '0;
      st_q    <= (state_d != IDLE) ? stage_d : '0;
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_load     = load_q;
  assign bus.o_bf_valid = bfv_q;
  assign bus.o_addr_a   = a_q;
  assign bus.o_addr_b   = b_q;
  assign bus.o_tw_idx   = tw_q;
  assign bus.o_stage    = st_q;
  assign bus.o_done     = done_q;

`ifdef FFT8_CTRL_INVERSE_EN
  logic inv_q, inv_d, conj_q;

  // tracks i_inverse while idle so the start edge captures it
  assign inv_d = (state_q == IDLE) ? bus.i_inverse : inv_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      inv_q  <= 1'b0;
      conj_q <= 1'b0;
    end else begin
      inv_q  <= inv_d;
      conj_q <= (state_d != IDLE) && inv_d;
    end
  end

  assign bus.o_tw_conj = conj_q;
`endif

  fft8_wb_delay #(
    .LATENCY (BF_LATENCY)
  ) u_wb (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .flush_i  (abort_hit),
    .valid_i  (bfv_q),
    .addr_a_i (a_q),
    .addr_b_i (b_q),
    .valid_o  (bus.o_wb_valid),
    .addr_a_o (bus.o_wb_addr_a),
    .addr_b_o (bus.o_wb_addr_b)
  );

endmodule

// File: tb/tb_fft8_ctrl.sv
// tb_fft8_ctrl: scoreboard bench for fft8_ctrl at BF_LATENCY 2, 1, 5.
// Directed runs: plain, stray start, abort+restart, reset mid-run.
module tb_fft8_ctrl;
  import fft8_pkg::*;

  typedef struct {
    int         cyc;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [1:0] st;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_r = '0;
  logic [2:0] abort_r = '0;
  logic       inv_r = 1'b0;
  logic       idle_chk = 1'b0;

  int ecount = 0;
  int ncmp = 0;
  int nbad = 0;

  ev_t  q_bf [3][$];
  ev_t  q_wb [3][$];
  int   q_done [3][$];
  int   lo [3] = '{-100, -100, -100};
  int   hi [3] = '{-200, -200, -200};
  logic inv_exp [3];
  logic [7:0] pend [3];

  int TA [12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
  int TB [12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
  int TT [12] = '{0,0,0,0, 0,2,0,2, 0,1,2,3};

  always #5 clk = ~clk;
  always @(posedge clk) ecount++;

  function automatic int lat(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 5);
  endfunction

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h",
               nm, g, ecount + 1, act, exp);
    end
  endtask

  // cut = last cycle of normal operation (abort/reset edge)
  task automatic push_run(input int g, input int t0,
                          input int cut, input logic inv);
    int  L, s, ic, dn;
    ev_t e;
    L = lat(g);
    for (int i = 0; i < 12; i++) begin
      s  = i / 4;
      ic = 2 + s * (4 + L) + (i % 4);
      e.a  = 3'(TA[i]);
      e.b  = 3'(TB[i]);
      e.tw = 2'(TT[i]);
      e.st = 2'(s);
      if (ic <= cut) begin
        e.cyc = t0 + ic;
        q_bf[g].push_back(e);
      end
      if (ic + L <= cut) begin
        e.cyc = t0 + ic + L;
        q_wb[g].push_back(e);
      end
    end
    dn = 14 + 3 * L;
    if (dn <= cut) q_done[g].push_back(t0 + dn);
    lo[g]      = t0 + 1;
    hi[g]      = t0 + ((cut < dn) ? cut : dn);
    inv_exp[g] = inv;
    pend[g]    = '0;
  endtask

  // call at a negedge: start sampled at the next posedge
  task automatic go(input logic [2:0] m, input logic inv,
                    input int cut);
    inv_r = inv;
    for (int g = 0; g < 3; g++) begin
      if (m[g]) begin
        start_r[g] = 1'b1;
        push_run(g, ecount + 1, cut, inv);
      end
    end
    @(negedge clk);
    start_r = '0;
  endtask

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LATS = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

    fft8_ctrl_if bus ();

    assign bus.i_start = start_r[g];
    assign bus.i_abort = abort_r[g];
`ifdef FFT8_CTRL_INVERSE_EN
    assign bus.i_inverse = inv_r;
`endif

    fft8_ctrl #(
      .NUM_POINTS (8),
      .BF_LATENCY (LATS)
    ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
    );

    always @(negedge clk) begin : mon
      int   c;
      logic bw;
      ev_t  e;
      c  = ecount + 1;
      bw = (c >= lo[g]) && (c <= hi[g]);
      if (idle_chk)
        chk("idle_zero", g, 32'({bus.o_busy, bus.o_load,
            bus.o_bf_valid, bus.o_addr_a, bus.o_addr_b,
            bus.o_tw_idx, bus.o_stage, bus.o_wb_valid,
            bus.o_wb_addr_a, bus.o_wb_addr_b, bus.o_done}), 0);
      chk("busy", g, 32'(bus.o_busy), 32'(bw));
      chk("load", g, 32'(bus.o_load), 32'(c == lo[g]));
`ifdef FFT8_CTRL_INVERSE_EN
      chk("tw_conj", g, 32'(bus.o_tw_conj),
          32'(bw && inv_exp[g]));
`endif
      if (bus.o_bf_valid ||
          (q_bf[g].size() > 0 && q_bf[g][0].cyc <= c)) begin
        if (q_bf[g].size() == 0) begin
          chk("bf_extra", g, 32'(bus.o_bf_valid), 0);
        end else begin
          e = q_bf[g].pop_front();
          chk("bf_tuple", g,
              {5'd0, 16'(c), bus.o_bf_valid, bus.o_addr_a,
               bus.o_addr_b, bus.o_tw_idx, bus.o_stage},
              {5'd0, 16'(e.cyc), 1'b1, e.a, e.b, e.tw, e.st});
        end
        if (bus.o_bf_valid)
          chk("hazard", g, 32'(pend[g][bus.o_addr_a] |
              pend[g][bus.o_addr_b]), 0);
      end
      if (bus.o_wb_valid ||
          (q_wb[g].size() > 0 && q_wb[g][0].cyc <= c)) begin
        if (q_wb[g].size() == 0) begin
          chk("wb_extra", g, 32'(bus.o_wb_valid), 0);
        end else begin
          e = q_wb[g].pop_front();
          chk("wb_tuple", g,
              {9'd0, 16'(c), bus.o_wb_valid,
               bus.o_wb_addr_a, bus.o_wb_addr_b},
              {9'd0, 16'(e.cyc), 1'b1, e.a, e.b});
        end
      end
      if (bus.o_done ||
          (q_done[g].size() > 0 && q_done[g][0] <= c)) begin
        if (q_done[g].size() == 0) begin
          chk("done_extra", g, 32'(bus.o_done), 0);
        end else begin
          chk("done", g, {15'd0, 16'(c), bus.o_done},
              {15'd0, 16'(q_done[g].pop_front()), 1'b1});
        end
      end
      if (bus.o_wb_valid) begin
        pend[g][bus.o_wb_addr_a] = 1'b0;
        pend[g][bus.o_wb_addr_b] = 1'b0;
      end
      if (bus.o_bf_valid) begin
        pend[g][bus.o_addr_a] = 1'b1;
        pend[g][bus.o_addr_b] = 1'b1;
      end
    end
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      pend[g]    = '0;
      inv_exp[g] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    idle_chk = 1'b1;
    repeat (10) @(negedge clk);
    idle_chk = 1'b0;

    // all three latencies in parallel, inverse requested
    go(3'b111, 1'b1, 1000);
    repeat (40) @(negedge clk);

    // stray start sampled in cycle 9 (stage 1 issue)
    go(3'b001, 1'b0, 1000);
    repeat (8) @(negedge clk);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (30) @(negedge clk);

    // abort sampled in cycle 9, restart on the next edge
    go(3'b001, 1'b0, 9);
    repeat (8) @(negedge clk);
    abort_r[0] = 1'b1;
    @(negedge clk);
    abort_r[0] = 1'b0;
    go(3'b001, 1'b0, 1000);
    repeat (30) @(negedge clk);

    // reset sampled in cycle 6
    go(3'b001, 1'b1, 6);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int g = 0; g < 3; g++)
      chk("queue_empty", g, 32'(q_bf[g].size() +
          q_wb[g].size() + q_done[g].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
